// File: rtl/rf_writeback_scheduler.sv
// rtl/rf_writeback_scheduler.sv - Round-robin ALU/load writeback arbiter with RAW/WAW busy scoreboard
module rf_writeback_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluAddr,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic                  rfWriteEnable,
    output logic [ADDR_WIDTH-1:0] rfWriteAddress,
    output logic [DATA_WIDTH-1:0] rfWriteData,
    input  logic                  issueReserve,
    input  logic [ADDR_WIDTH-1:0] issueDest,
    input  logic                  readEn1,
    input  logic [ADDR_WIDTH-1:0] srcAddr1,
    input  logic                  readEn2,
    input  logic [ADDR_WIDTH-1:0] srcAddr2,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busyBits
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e                  r_last_grant;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_alu_xfer;
    logic                  w_mem_xfer;
    logic                  w_stall;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clr_mask;

    // Under contention the source that did not win last time gets the port.
    always_comb begin
        aluReady = 1'b0;
        memReady = 1'b0;
        if (!reset) begin
            if (aluValid && memValid) begin
                aluReady = (r_last_grant == SRC_MEM);
                memReady = (r_last_grant == SRC_ALU);
            end else begin
                aluReady = aluValid;
                memReady = memValid;
            end
        end
    end

    assign w_alu_xfer = aluValid && aluReady;
    assign w_mem_xfer = memValid && memReady;

    assign w_stall = (readEn1 && r_busy[srcAddr1]) ||
                     (readEn2 && r_busy[srcAddr2]) ||
                     (issueReserve && r_busy[issueDest]);

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_set_mask[i] = issueReserve && !w_stall && (issueDest == ADDR_WIDTH'(i));
            w_clr_mask[i] = r_wr_en && (r_wr_addr == ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= '0;
            r_last_grant <= SRC_MEM;
        end else begin
            r_wr_en <= w_alu_xfer || w_mem_xfer;
            if (w_alu_xfer) begin
                r_wr_addr    <= aluAddr;
                r_wr_data    <= aluData;
                r_last_grant <= SRC_ALU;
            end else if (w_mem_xfer) begin
                r_wr_addr    <= memAddr;
                r_wr_data    <= memData;
                r_last_grant <= SRC_MEM;
            end
            // Set after clear: a fresh reservation outlives the retiring write.
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign rfWriteEnable  = r_wr_en;
    assign rfWriteAddress = r_wr_addr;
    assign rfWriteData    = r_wr_data;
    assign busyBits       = r_busy;
    assign stall          = w_stall;

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// tb/tb_rf_writeback_scheduler.sv - Directed plus randomized check of rf_writeback_scheduler against a reference model
module tb_rf_writeback_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid, memValid;
    logic [3:0]  aluAddr, memAddr;
    logic [31:0] aluData, memData;
    logic        aluReady, memReady;
    logic        rfWriteEnable;
    logic [3:0]  rfWriteAddress;
    logic [31:0] rfWriteData;
    logic        issueReserve;
    logic [3:0]  issueDest;
    logic        readEn1, readEn2;
    logic [3:0]  srcAddr1, srcAddr2;
    logic        stall;
    logic [15:0] busyBits;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_pending [16];
    bit          m_alu_turn;
    bit          m_wr_valid;
    logic [3:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_alu_took, m_mem_took;

    rf_writeback_scheduler dut (
        .clk(clk), .reset(reset),
        .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
        .rfWriteEnable(rfWriteEnable), .rfWriteAddress(rfWriteAddress), .rfWriteData(rfWriteData),
        .issueReserve(issueReserve), .issueDest(issueDest),
        .readEn1(readEn1), .srcAddr1(srcAddr1), .readEn2(readEn2), .srcAddr2(srcAddr2),
        .stall(stall), .busyBits(busyBits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pending[i];
        return v;
    endfunction

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit exp_ar, exp_mr, exp_st;
        @(negedge clk);
        exp_ar = 0;
        exp_mr = 0;
        if (!reset) begin
            if (aluValid && memValid) begin
                exp_ar = m_alu_turn;
                exp_mr = !m_alu_turn;
            end else begin
                exp_ar = aluValid;
                exp_mr = memValid;
            end
        end
        exp_st = (readEn1 && m_pending[srcAddr1]) || (readEn2 && m_pending[srcAddr2]) ||
                 (issueReserve && m_pending[issueDest]);
        chk("aluReady", 32'(aluReady), 32'(exp_ar));
        chk("memReady", 32'(memReady), 32'(exp_mr));
        chk("stall", 32'(stall), 32'(exp_st));
        chk("busyBits", 32'(busyBits), 32'(model_busy()));
        chk("rfWriteEnable", 32'(rfWriteEnable), 32'(m_wr_valid));
        if (m_wr_valid) begin
            chk("rfWriteAddress", 32'(rfWriteAddress), 32'(m_wr_addr));
            chk("rfWriteData", rfWriteData, m_wr_data);
        end
        @(posedge clk);
        m_alu_took = exp_ar && aluValid;
        m_mem_took = exp_mr && memValid;
        if (reset) begin
            foreach (m_pending[i]) m_pending[i] = 0;
            m_alu_turn = 1;
            m_wr_valid = 0;
        end else begin
            if (m_wr_valid) m_pending[m_wr_addr] = 0;
            if (issueReserve && !exp_st) m_pending[issueDest] = 1;
            m_wr_valid = m_alu_took || m_mem_took;
            if (m_alu_took) begin
                m_wr_addr  = aluAddr;
                m_wr_data  = aluData;
                m_alu_turn = 0;
            end else if (m_mem_took) begin
                m_wr_addr  = memAddr;
                m_wr_data  = memData;
                m_alu_turn = 1;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1; aluValid = 0; memValid = 0; aluAddr = 0; memAddr = 0;
        aluData = 0; memData = 0; issueReserve = 0; issueDest = 0;
        readEn1 = 0; readEn2 = 0; srcAddr1 = 0; srcAddr2 = 0;
        foreach (m_pending[i]) m_pending[i] = 0;
        m_alu_turn = 1; m_wr_valid = 0; m_wr_addr = 0; m_wr_data = 0;
        cycle();
        cycle();
        reset = 0;
        chk("reset_we", 32'(rfWriteEnable), 32'd0);
        chk("reset_addr", 32'(rfWriteAddress), 32'd0);
        chk("reset_data", rfWriteData, 32'd0);
        chk("reset_busy", 32'(busyBits), 32'd0);

        readEn1 = 1; readEn2 = 1;
        for (int a = 0; a < 16; a++) begin
            srcAddr1 = 4'(a); srcAddr2 = 4'(15 - a);
            cycle();
        end
        readEn1 = 0; readEn2 = 0;

        // Single ALU write
        aluValid = 1; aluAddr = 3; aluData = 32'hD;
        cycle();
        aluValid = 0;
        chk("single_we", 32'(rfWriteEnable), 32'd1);
        chk("single_addr", 32'(rfWriteAddress), 32'd3);
        chk("single_data", rfWriteData, 32'hD);
        cycle();
        chk("single_we_off", 32'(rfWriteEnable), 32'd0);

        // Contention right after reset: ALU, MEM, ALU, MEM
        reset = 1;
        cycle();
        reset = 0;
        aluValid = 1; aluAddr = 1; aluData = 32'hA1;
        memValid = 1; memAddr = 2; memData = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("contend_addr", 32'(rfWriteAddress), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        aluValid = 0; memValid = 0;
        cycle();
        cycle();

        // RAW on register 5
        issueReserve = 1; issueDest = 5;
        cycle();
        issueReserve = 0;
        chk("raw_busy5", 32'(busyBits[5]), 32'd1);
        readEn1 = 1; srcAddr1 = 5;
        cycle();
        memValid = 1; memAddr = 5; memData = 32'h55;
        cycle();
        memValid = 0;
        cycle();
        chk("raw_stall_clear", 32'(stall), 32'd0);
        cycle();
        readEn1 = 0;

        // WAW on register 7
        issueReserve = 1; issueDest = 7;
        cycle();
        cycle();
        issueReserve = 0;
        chk("waw_busy7", 32'(busyBits[7]), 32'd1);
        aluValid = 1; aluAddr = 7; aluData = 32'h77;
        cycle();
        aluValid = 0;
        cycle();
        chk("waw_cleared", 32'(busyBits[7]), 32'd0);
        aluValid = 1; aluAddr = 7; aluData = 32'h78;
        cycle();
        aluValid = 0; issueReserve = 1; issueDest = 7;
        cycle();
        issueReserve = 0;
        chk("set_wins", 32'(busyBits[7]), 32'd1);

        // Reset with a write presented, after an ALU grant
        aluValid = 1; aluAddr = 9; aluData = 32'h99;
        reset = 1;
        cycle();
        reset = 0; aluValid = 0;
        chk("rst_mid_we", 32'(rfWriteEnable), 32'd0);
        chk("rst_mid_busy", 32'(busyBits), 32'd0);
        aluValid = 1; aluAddr = 4'hA; aluData = 32'hAA;
        memValid = 1; memAddr = 4'hB; memData = 32'hBB;
        cycle();
        chk("rst_alu_first", 32'(rfWriteAddress), 32'hA);
        aluValid = 0; memValid = 0;
        cycle();

        // Randomized traffic; valid/addr/data held until the model says accepted
        for (int n = 0; n < 3000; n++) begin
            if (aluValid && m_alu_took) aluValid = 0;
            if (memValid && m_mem_took) memValid = 0;
            if (!aluValid && ($urandom_range(0, 3) != 0)) begin
                aluValid = 1; aluAddr = 4'($urandom); aluData = $urandom;
            end
            if (!memValid && ($urandom_range(0, 2) == 0)) begin
                memValid = 1; memAddr = 4'($urandom); memData = $urandom;
            end
            issueReserve = ($urandom_range(0, 2) == 0);
            issueDest    = 4'($urandom);
            readEn1      = $urandom_range(0, 1) == 1;
            srcAddr1     = 4'($urandom);
            readEn2      = $urandom_range(0, 1) == 1;
            srcAddr2     = 4'($urandom);
            reset        = ($urandom_range(0, 199) == 0);
            if (reset) begin
                aluValid = 0; memValid = 0;
            end
            cycle();
            if (reset) begin
                m_alu_took = 0; m_mem_took = 0;
            end
            reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
